carregador_programa: RTL and testbench

- Program loader upstream of the instruction memory and the program counter.
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words.
- Writes each word to the instruction memory write port at consecutive word addresses.
- Asserts a release flag once the whole program is in memory; the CPU and PC are held until then.

---
 rtl/carregador_programa_if.sv | 28 ++
 rtl/carregador_programa.sv | 132 +++++++++++++
 tb/tb_carregador_programa.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_programa_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// The slave modport is the loader's side; master is the byte source/memory side.
interface carregador_programa_if;
    logic [7:0]  byte_entrada;
    logic        byte_valido;
    logic        byte_pronto;
    logic        mem_we;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado;

    modport master (
        output byte_entrada,
        output byte_valido,
        input  byte_pronto,
        input  mem_we,
        input  mem_endereco,
        input  mem_dado
    );

    modport slave (
        input  byte_entrada,
        input  byte_valido,
        output byte_pronto,
        output mem_we,
        output mem_endereco,
        output mem_dado
    );
endinterface

// File: rtl/carregador_programa.sv
// Program loader: 16-bit word-count header, then big-endian 32-bit words written to
// consecutive instruction-memory addresses; holds the CPU until the program is complete.
module carregador_programa #(
    parameter int unsigned PROFUNDIDADE  = 256,
    parameter logic [31:0] ENDERECO_BASE = 32'h00000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        iniciar,
    carregador_programa_if.slave        bus,
    output logic [15:0]                 palavras_carregadas,
    output logic                        cpu_liberado,
    output logic                        erro
);

    typedef enum logic [2:0] {
        StOcioso,
        StCabecalho,
        StCarga,
        StEscrita,
        StPronto,
        StErro
    } estado_e;

    localparam logic [16:0] LimitePalavras = 17'(PROFUNDIDADE);

    estado_e     estado_q, estado_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  cnt_byte_q, cnt_byte_d;
    logic [31:0] palavra_q, palavra_d;
    logic [15:0] palavras_q, palavras_d;
    logic [31:0] endereco_q, endereco_d;
    logic [31:0] dado_q, dado_d;

    logic        pronto;
    logic        aceita;
    logic [15:0] n_novo;
    logic [31:0] palavra_nova;
    logic [15:0] palavras_inc;

    assign pronto       = (estado_q == StCabecalho) || (estado_q == StCarga);
    assign aceita       = bus.byte_valido && pronto;
    assign n_novo       = {n_q[15:8], bus.byte_entrada};
    assign palavra_nova = {palavra_q[23:0], bus.byte_entrada};
    assign palavras_inc = palavras_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= StOcioso;
            n_q        <= '0;
            cnt_byte_q <= '0;
            palavra_q  <= '0;
            palavras_q <= '0;
            endereco_q <= ENDERECO_BASE;
            dado_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            n_q        <= n_d;
            cnt_byte_q <= cnt_byte_d;
            palavra_q  <= palavra_d;
            palavras_q <= palavras_d;
            endereco_q <= endereco_d;
            dado_q     <= dado_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        n_d        = n_q;
        cnt_byte_d = cnt_byte_q;
        palavra_d  = palavra_q;
        palavras_d = palavras_q;
        endereco_d = endereco_q;
        dado_d     = dado_q;

        case (estado_q)
            StOcioso, StPronto, StErro: begin
                if (iniciar) begin
                    estado_d   = StCabecalho;
                    palavras_d = '0;
                    cnt_byte_d = '0;
                end
            end
            StCabecalho: begin
                if (aceita) begin
                    if (cnt_byte_q == 2'd0) begin
                        n_d[15:8]  = bus.byte_entrada;
                        cnt_byte_d = 2'd1;
                    end else begin
                        n_d        = n_novo;
                        cnt_byte_d = '0;
                        if (n_novo == 16'd0) begin
                            estado_d = StPronto;
                        end else if ({1'b0, n_novo} > LimitePalavras) begin
                            estado_d = StErro;
                        end else begin
                            estado_d = StCarga;
                        end
                    end
                end
            end
            StCarga: begin
                if (aceita) begin
                    palavra_d  = palavra_nova;
                    cnt_byte_d = cnt_byte_q + 2'd1;
                    // Latch the write payload now so it is stable for the single ESCRITA cycle.
                    if (cnt_byte_q == 2'd3) begin
                        estado_d   = StEscrita;
                        dado_d     = palavra_nova;
                        endereco_d = ENDERECO_BASE + 32'({palavras_q, 2'b00});
                    end
                end
            end
            StEscrita: begin
                palavras_d = palavras_inc;
                estado_d   = (palavras_inc == n_q) ? StPronto : StCarga;
            end
            default: begin
                estado_d = StOcioso;
            end
        endcase
    end

    assign bus.byte_pronto    = pronto;
    assign bus.mem_we         = (estado_q == StEscrita);
    assign bus.mem_endereco   = endereco_q;
    assign bus.mem_dado       = dado_q;
    assign palavras_carregadas = palavras_q;
    assign cpu_liberado        = (estado_q == StPronto);
    assign erro                = (estado_q == StErro);

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: expected memory writes go into a queue and a
// negedge monitor pops and compares them whenever mem_we is seen.
module tb_carregador_programa;

    localparam logic [31:0] BASE = 32'h00000000;

    logic        clk;
    logic        reset;
    logic        iniciar;
    logic [15:0] palavras_carregadas;
    logic        cpu_liberado;
    logic        erro;

    carregador_programa_if bus ();

    carregador_programa #(
        .PROFUNDIDADE (256),
        .ENDERECO_BASE(BASE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .iniciar            (iniciar),
        .bus                (bus.slave),
        .palavras_carregadas(palavras_carregadas),
        .cpu_liberado       (cpu_liberado),
        .erro               (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] esperado[$];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
        total++;
        if (atual !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nome, atual, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] ender, input logic [31:0] dado);
        esperado.push_back({ender, dado});
    endtask

    // Presents a byte and returns just after the edge that accepted it; valid stays high.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.byte_entrada = b;
        bus.byte_valido  = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.byte_pronto) ok = 1'b1;
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %02h never accepted", b);
        end
    endtask

    task automatic idle();
        bus.byte_valido = 1'b0;
        tick();
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_byte_pronto", 32'(bus.byte_pronto), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_endereco", bus.mem_endereco, BASE);
        check("rst_mem_dado", bus.mem_dado, 32'd0);
        check("rst_palavras", 32'(palavras_carregadas), 32'd0);
        check("rst_cpu_liberado", 32'(cpu_liberado), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
    endtask

    // Monitor: write must follow an accepted byte by one cycle, last one cycle, and match.
    initial begin
        logic        prev_we;
        logic        prev_aceite;
        logic [63:0] e;
        prev_we     = 1'b0;
        prev_aceite = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                check("we_latency", 32'(prev_aceite), 32'd1);
                if (esperado.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %08h data %08h",
                             bus.mem_endereco, bus.mem_dado);
                end else begin
                    e = esperado.pop_front();
                    check("write_addr", bus.mem_endereco, e[63:32]);
                    check("write_data", bus.mem_dado, e[31:0]);
                end
            end
            prev_we     = bus.mem_we;
            prev_aceite = bus.byte_valido && bus.byte_pronto && !reset;
        end
    end

    initial begin
        reset            = 1'b1;
        iniciar          = 1'b0;
        bus.byte_entrada = 8'h00;
        bus.byte_valido  = 1'b0;
        tick();
        tick();
        check_reset_values();
        reset = 1'b0;
        tick();
        check("ocioso_byte_pronto", 32'(bus.byte_pronto), 32'd0);

        // Two words back-to-back.
        pulse_iniciar();
        check("cab_byte_pronto", 32'(bus.byte_pronto), 32'd1);
        expect_write(BASE + 32'h0, 32'h20080005);
        expect_write(BASE + 32'h4, 32'h01095020);
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'h01); send(8'h09); send(8'h50); send(8'h20);
        idle();
        check("t1_palavras", 32'(palavras_carregadas), 32'd2);
        check("t1_cpu_liberado", 32'(cpu_liberado), 32'd1);

        // Empty program.
        pulse_iniciar();
        check("t2_cpu_cleared", 32'(cpu_liberado), 32'd0);
        check("t2_palavras_cleared", 32'(palavras_carregadas), 32'd0);
        send(8'h00); send(8'h00);
        bus.byte_valido = 1'b0;
        check("t2_cpu_liberado", 32'(cpu_liberado), 32'd1);
        check("t2_palavras", 32'(palavras_carregadas), 32'd0);
        check("t2_byte_pronto", 32'(bus.byte_pronto), 32'd0);

        // Oversized header.
        pulse_iniciar();
        send(8'h01); send(8'h01);
        bus.byte_valido = 1'b0;
        check("t3_erro", 32'(erro), 32'd1);
        check("t3_byte_pronto", 32'(bus.byte_pronto), 32'd0);
        tick();
        check("t3_erro_held", 32'(erro), 32'd1);
        pulse_iniciar();
        check("t3_erro_cleared", 32'(erro), 32'd0);
        check("t3_byte_pronto_back", 32'(bus.byte_pronto), 32'd1);

        // Gapped valid plus a byte offered during ESCRITA (already in CABECALHO).
        expect_write(BASE + 32'h0, 32'hAABBCCDD);
        send(8'h00); idle(); send(8'h01); idle();
        send(8'hAA); idle(); send(8'hBB); idle(); send(8'hCC); idle(); send(8'hDD);
        check("t4_we_now", 32'(bus.mem_we), 32'd1);
        bus.byte_entrada = 8'h11;
        bus.byte_valido  = 1'b1;
        tick();
        bus.byte_valido = 1'b0;
        check("t4_palavras", 32'(palavras_carregadas), 32'd1);
        check("t4_cpu_liberado", 32'(cpu_liberado), 32'd1);

        // Reset in the middle of a word.
        pulse_iniciar();
        send(8'h00); send(8'h02); send(8'hAA); send(8'h55);
        bus.byte_valido = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_values();
        reset = 1'b0;
        tick();
        tick();
        check("t5_no_write_after_reset", 32'(bus.mem_we), 32'd0);
        pulse_iniciar();
        expect_write(BASE + 32'h0, 32'h12345678);
        send(8'h00); send(8'h01);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        idle();
        check("t5_palavras", 32'(palavras_carregadas), 32'd1);
        check("t5_cpu_liberado", 32'(cpu_liberado), 32'd1);

        // iniciar during CARGA is ignored, then a second session restarts from 0.
        pulse_iniciar();
        expect_write(BASE + 32'h0, 32'hDEADBEEF);
        expect_write(BASE + 32'h4, 32'hCAFEBABE);
        send(8'h00); send(8'h02); send(8'hDE); send(8'hAD);
        iniciar = 1'b1;
        send(8'hBE);
        iniciar = 1'b0;
        send(8'hEF);
        send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
        idle();
        check("t6_palavras", 32'(palavras_carregadas), 32'd2);
        check("t6_cpu_liberado", 32'(cpu_liberado), 32'd1);
        pulse_iniciar();
        check("t6_palavras_restart", 32'(palavras_carregadas), 32'd0);
        expect_write(BASE + 32'h0, 32'h01020304);
        send(8'h00); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle();
        check("t6b_palavras", 32'(palavras_carregadas), 32'd1);
        check("t6b_cpu_liberado", 32'(cpu_liberado), 32'd1);

        tick();
        tick();
        check("scoreboard_drained", 32'(esperado.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
